// File: rtl/retire_store_buffer.sv
// rtl/retire_store_buffer.sv - post-commit write-combining store buffer with in-order drain and load forwarding

module retire_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_ready,
  input  logic [ADDR_W-1:0]        mem_address,
  input  logic [DATA_W-1:0]        retire_rs2_data,
  output logic                     store_executed,
  output logic                     mem_wr_en,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  input  logic                     mem_wr_ack,
  input  logic                     ld_check,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic                     sb_full,
  output logic                     sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [DATA_W-1:0]   data_q [DEPTH];

  logic [DEPTH-1:0]    locked_mask;
  logic [DEPTH-1:0]    combinable;
  logic                combine_hit;
  logic [PTR_W-1:0]    combine_idx;
  logic                ld_comb_hit;
  logic [DATA_W-1:0]   ld_comb_data;
  logic                ld_head_hit;
  logic                alloc;
  logic                pop;

  // The head is locked while its write is in flight; everything else may absorb stores or forward
  always_comb begin
    locked_mask = '0;
    if (state_q == WRITE) locked_mask[head_q] = 1'b1;
    combinable = valid_q & ~locked_mask;
  end

  // Address match against combinable entries for both store combining and load forwarding
  always_comb begin
    combine_hit  = 1'b0;
    combine_idx  = '0;
    ld_comb_hit  = 1'b0;
    ld_comb_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (store_ready && combinable[i] && (addr_q[i] == mem_address)) begin
        combine_hit = 1'b1;
        combine_idx = PTR_W'(i);
      end
      if (ld_check && combinable[i] && (addr_q[i] == ld_addr)) begin
        ld_comb_hit  = 1'b1;
        ld_comb_data = data_q[i];
      end
    end
  end

  assign sb_count = count_q;
  assign sb_full  = (count_q == CNT_W'(DEPTH));
  assign sb_empty = (count_q == '0);

  // Full uses the registered count, so a slot freed by an ack is only reusable next cycle
  assign store_executed = store_ready & (combine_hit | ~sb_full);
  assign alloc          = store_executed & ~combine_hit;
  assign pop            = (state_q == WRITE) & mem_wr_ack;

  assign mem_wr_en   = (state_q == WRITE);
  assign mem_wr_addr = addr_q[head_q];
  assign mem_wr_data = data_q[head_q];

  // A younger unlocked match wins over the older locked head
  always_comb begin
    ld_head_hit = ld_check & (state_q == WRITE) & valid_q[head_q] & (addr_q[head_q] == ld_addr);
    ld_hit      = ld_comb_hit | ld_head_hit;
    if (ld_comb_hit)      ld_data = ld_comb_data;
    else if (ld_head_hit) ld_data = data_q[head_q];
    else                  ld_data = '0;
  end

  // Next-state for pointers, occupancy, valid bits and the drain FSM
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    state_d = state_q;
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    // Alloc and pop never touch the same slot: pop needs count>=1, alloc needs count<DEPTH
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case (state_q)
      IDLE:    if (count_q != '0) state_d = WRITE;
      WRITE:   if (pop && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register with synchronous reset; a reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; qualified by valid_q so it needs no reset
  always_ff @(posedge clk) begin
    if (!rst && store_executed) begin
      if (combine_hit) begin
        data_q[combine_idx] <= retire_rs2_data;
      end else begin
        addr_q[tail_q] <= mem_address;
        data_q[tail_q] <= retire_rs2_data;
      end
    end
  end

endmodule

// File: tb/tb_retire_store_buffer.sv
// tb/tb_retire_store_buffer.sv - directed table-driven bench for retire_store_buffer

module tb_retire_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              store_ready;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] retire_rs2_data;
  logic              store_executed;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ack;
  logic              ld_check;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic [2:0]        sb_count;
  logic              sb_full;
  logic              sb_empty;

  int checks = 0;
  int errors = 0;

  retire_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .store_ready     (store_ready),
    .mem_address     (mem_address),
    .retire_rs2_data (retire_rs2_data),
    .store_executed  (store_executed),
    .mem_wr_en       (mem_wr_en),
    .mem_wr_addr     (mem_wr_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_wr_ack      (mem_wr_ack),
    .ld_check        (ld_check),
    .ld_addr         (ld_addr),
    .ld_hit          (ld_hit),
    .ld_data         (ld_data),
    .sb_count        (sb_count),
    .sb_full         (sb_full),
    .sb_empty        (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ack;
    logic        ldc;
    logic [31:0] lda;
    logic        e_exec;
    logic        e_wren;
    logic [31:0] e_waddr;
    logic [31:0] e_wdata;
    int          e_cnt;
    logic        e_hit;
    logic [31:0] e_ldata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic sr, input logic [31:0] addr, input logic [31:0] data,
                     input logic ack, input logic ldc, input logic [31:0] lda,
                     input logic e_exec, input logic e_wren, input logic [31:0] e_waddr,
                     input logic [31:0] e_wdata, input int e_cnt, input logic e_hit,
                     input logic [31:0] e_ldata);
    vec_t v;
    v.sr = sr; v.addr = addr; v.data = data; v.ack = ack; v.ldc = ldc; v.lda = lda;
    v.e_exec = e_exec; v.e_wren = e_wren; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_cnt = e_cnt; v.e_hit = e_hit; v.e_ldata = e_ldata;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    store_ready = 0; mem_address = '0; retire_rs2_data = '0;
    mem_wr_ack = 0; ld_check = 0; ld_addr = '0;
  endtask

  int wr;
  int k;
  logic acc;
  logic seen;

  initial begin
    rst = 1;
    drive_idle();

    // single store
    add(1, 'h100, 'hAA, 0, 0, 0,      1, 0, 0, 0,          0, 0, 0);
    add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0,          1, 0, 0);
    add(0, 0, 0, 0, 1, 'h100,         0, 1, 'h100, 'hAA,   1, 1, 'hAA);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h100, 'hAA,   1, 0, 0);
    add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0,          0, 0, 0);
    // fill with memory stalled, then full back-pressure
    add(1, 'h0, 'h10, 0, 0, 0,        1, 0, 0, 0,          0, 0, 0);
    add(1, 'h4, 'h14, 0, 0, 0,        1, 0, 0, 0,          1, 0, 0);
    add(1, 'h8, 'h18, 0, 0, 0,        1, 1, 'h0, 'h10,     2, 0, 0);
    add(1, 'hC, 'h1C, 0, 0, 0,        1, 1, 'h0, 'h10,     3, 0, 0);
    add(1, 'h10, 'h20, 0, 1, 'hC,     0, 1, 'h0, 'h10,     4, 1, 'h1C);
    add(1, 'h10, 'h20, 1, 0, 0,       0, 1, 'h0, 'h10,     4, 0, 0);
    add(1, 'h10, 'h20, 0, 0, 0,       1, 1, 'h4, 'h14,     3, 0, 0);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h4, 'h14,     4, 0, 0);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h8, 'h18,     3, 0, 0);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'hC, 'h1C,     2, 0, 0);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h10, 'h20,    1, 0, 0);
    add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0,          0, 0, 0);
    // write combine into a non-head entry
    add(1, 'h20, 1, 0, 0, 0,          1, 0, 0, 0,          0, 0, 0);
    add(1, 'h24, 2, 0, 0, 0,          1, 0, 0, 0,          1, 0, 0);
    add(1, 'h24, 3, 0, 0, 0,          1, 1, 'h20, 1,       2, 0, 0);
    add(0, 0, 0, 0, 1, 'h24,          0, 1, 'h20, 1,       2, 1, 3);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h20, 1,       2, 0, 0);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h24, 3,       1, 0, 0);
    add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0,          0, 0, 0);
    // locked head: same address allocates a new entry
    add(1, 'h40, 5, 0, 0, 0,          1, 0, 0, 0,          0, 0, 0);
    add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0,          1, 0, 0);
    add(1, 'h40, 6, 0, 1, 'h40,       1, 1, 'h40, 5,       1, 1, 5);
    add(0, 0, 0, 0, 1, 'h40,          0, 1, 'h40, 5,       2, 1, 6);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h40, 5,       2, 0, 0);
    add(0, 0, 0, 1, 0, 0,             0, 1, 'h40, 6,       1, 0, 0);
    add(0, 0, 0, 0, 1, 'h40,          0, 0, 0, 0,          0, 0, 0);
    // combine into head on the IDLE->WRITE cycle
    add(1, 'h50, 7, 0, 0, 0,          1, 0, 0, 0,          0, 0, 0);
    add(1, 'h50, 8, 0, 0, 0,          1, 0, 0, 0,          1, 0, 0);
    add(0, 0, 0, 1, 1, 'h50,          0, 1, 'h50, 8,       1, 1, 8);
    add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0,          0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset sb_empty", sb_empty, 1);
    chk("reset sb_full", sb_full, 0);
    chk("reset sb_count", sb_count, 0);
    chk("reset mem_wr_en", mem_wr_en, 0);
    chk("reset store_executed", store_executed, 0);
    chk("reset ld_hit", ld_hit, 0);
    chk("reset ld_data", ld_data, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      store_ready = vecs[i].sr; mem_address = vecs[i].addr; retire_rs2_data = vecs[i].data;
      mem_wr_ack = vecs[i].ack; ld_check = vecs[i].ldc; ld_addr = vecs[i].lda;
      #1;
      chk($sformatf("v%0d store_executed", i), store_executed, vecs[i].e_exec);
      chk($sformatf("v%0d mem_wr_en", i), mem_wr_en, vecs[i].e_wren);
      if (vecs[i].e_wren) begin
        chk($sformatf("v%0d mem_wr_addr", i), mem_wr_addr, vecs[i].e_waddr);
        chk($sformatf("v%0d mem_wr_data", i), mem_wr_data, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d sb_count", i), sb_count, 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d sb_full", i), sb_full, 64'(vecs[i].e_cnt == DEPTH));
      chk($sformatf("v%0d sb_empty", i), sb_empty, 64'(vecs[i].e_cnt == 0));
      chk($sformatf("v%0d ld_hit", i), ld_hit, vecs[i].e_hit);
      chk($sformatf("v%0d ld_data", i), ld_data, vecs[i].e_ldata);
    end

    // wrap: 10 stores streamed with ack every cycle
    wr = 0;
    k = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      drive_idle();
      mem_wr_ack = 1;
      if (k < 10) begin
        store_ready = 1;
        mem_address = 32'h200 + 32'(4 * k);
        retire_rs2_data = 32'h1000 + 32'(k);
      end
      #1;
      if (mem_wr_en) begin
        if (wr < 10) begin
          chk($sformatf("wrap addr %0d", wr), mem_wr_addr, 32'h200 + 32'(4 * wr));
          chk($sformatf("wrap data %0d", wr), mem_wr_data, 32'h1000 + 32'(wr));
        end
        wr++;
      end
      acc = store_executed;
      @(posedge clk);
      if (acc) k++;
    end
    chk("wrap stores accepted", 64'(k), 10);
    chk("wrap writes seen", 64'(wr), 10);
    @(negedge clk);
    drive_idle();
    #1;
    chk("wrap drained empty", sb_empty, 1);

    // reset while WRITE with 3 entries
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_idle();
      store_ready = 1;
      mem_address = 32'h300 + 32'(4 * i);
      retire_rs2_data = 32'h30 + 32'(i);
      #1;
      chk($sformatf("rst fill exec %0d", i), store_executed, 1);
    end
    @(negedge clk);
    drive_idle();
    #1;
    chk("rst pre count", sb_count, 3);
    chk("rst pre wr_en", mem_wr_en, 1);
    chk("rst pre wr_addr", mem_wr_addr, 32'h300);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst post empty", sb_empty, 1);
    chk("rst post wr_en", mem_wr_en, 0);
    mem_wr_ack = 1;
    @(negedge clk);
    mem_wr_ack = 0;
    #1;
    chk("late ack count", sb_count, 0);
    chk("late ack wr_en", mem_wr_en, 0);

    // buffer still works after reset
    @(negedge clk);
    store_ready = 1; mem_address = 32'h400; retire_rs2_data = 32'h44;
    #1;
    chk("post rst exec", store_executed, 1);
    seen = 0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      drive_idle();
      mem_wr_ack = 1;
      #1;
      if (mem_wr_en) begin
        seen = 1;
        chk("post rst wr_addr", mem_wr_addr, 32'h400);
        chk("post rst wr_data", mem_wr_data, 32'h44);
      end
    end
    chk("post rst write seen", seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
